// File: rtl/cache_controller.sv
// cache_controller: single-word CPU load/store front end for a set-associative write-back cache
// clk/rst                : clock, asynchronous active-high reset
// cpu_req_* / cpu_resp_* : CPU request (valid/ready) and one-cycle response pulse
// arr_*                  : cache array request (address, write data, enables, tag/valid/dirty) and 1-cycle read data
// mem_*                  : next-level memory request (writeback / refill) and refill response
module cache_controller #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int SETS            = 1024,
    parameter int WAYS            = 2,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE / 8))
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic                            cpu_req_we,
    input  logic [ADDRESS_WIDTH-1:0]        cpu_req_addr,
    input  logic [CACHE_LINE_SIZE-1:0]      cpu_req_wdata,
    input  logic [CACHE_LINE_SIZE/8-1:0]    cpu_req_strobe,
    output logic                            cpu_resp_valid,
    output logic [CACHE_LINE_SIZE-1:0]      cpu_resp_rdata,
    output logic                            arr_req_valid,
    output logic [ADDRESS_WIDTH-1:0]        arr_address,
    output logic [CACHE_LINE_SIZE-1:0]      arr_data,
    output logic [CACHE_LINE_SIZE/8-1:0]    arr_strobe,
    output logic [WAYS-1:0]                 arr_wen_data,
    output logic [WAYS-1:0]                 arr_wen_tag,
    output logic [2*WAYS-1:0]               arr_valid_dirty,
    output logic [TAG_WIDTH-1:0]            arr_tag,
    input  logic [CACHE_LINE_SIZE*WAYS-1:0] arr_data_out,
    input  logic [2*WAYS-1:0]               arr_valid_dirty_out,
    input  logic [TAG_WIDTH*WAYS-1:0]       arr_tag_out,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]        mem_req_addr,
    output logic [CACHE_LINE_SIZE-1:0]      mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [CACHE_LINE_SIZE-1:0]      mem_resp_rdata
);
    localparam int BYTES = CACHE_LINE_SIZE / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, REFILL_WAIT} state_t;

    state_t                     state, state_next;
    logic                       req_we;
    logic [ADDRESS_WIDTH-1:0]   req_addr;
    logic [CACHE_LINE_SIZE-1:0] req_wdata;
    logic [BYTES-1:0]           req_strobe;
    logic [WAY_W-1:0]           rr, vic;
    logic [CACHE_LINE_SIZE-1:0] vic_data;
    logic [TAG_WIDTH-1:0]       vic_tag;

    logic [TAG_WIDTH-1:0]       req_tag;
    logic [SET_W-1:0]           req_set;
    logic                       accept, hit, all_valid, vic_dirty;
    logic [WAY_W-1:0]           hit_way, inv_way, vic_sel;
    logic [CACHE_LINE_SIZE-1:0] merged;

    assign req_tag   = req_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign req_set   = req_addr[OFF_W +: SET_W];
    // reset gates acceptance so nothing leaks onto the array port while rst is held
    assign accept    = state == IDLE && cpu_req_valid && !rst;
    assign vic_sel   = all_valid ? rr : inv_way;
    assign vic_dirty = arr_valid_dirty_out[2*vic_sel +: 2] == 2'b11;

    // descending scan so the lowest matching / invalid way wins
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        all_valid = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (arr_valid_dirty_out[2*i] && arr_tag_out[i*TAG_WIDTH +: TAG_WIDTH] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!arr_valid_dirty_out[2*i]) begin
                all_valid = 1'b0;
                inv_way   = WAY_W'(i);
            end
        end
    end

    // refill line with the pending store's bytes laid over it
    always_comb begin
        merged = mem_resp_rdata;
        for (int b = 0; b < BYTES; b++)
            merged[8*b +: 8] = (req_we && req_strobe[b]) ? req_wdata[8*b +: 8] : mem_resp_rdata[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_strobe <= '0;
            rr         <= '0;
            vic        <= '0;
            vic_data   <= '0;
            vic_tag    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_we     <= cpu_req_we;
                req_addr   <= cpu_req_addr;
                req_wdata  <= cpu_req_wdata;
                req_strobe <= cpu_req_strobe;
            end
            if (state == LOOKUP && !hit) begin
                vic      <= vic_sel;
                vic_data <= arr_data_out[vic_sel*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                vic_tag  <= arr_tag_out[vic_sel*TAG_WIDTH +: TAG_WIDTH];
                if (all_valid)
                    rr <= rr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        cpu_req_ready   = state == IDLE;
        cpu_resp_valid  = 1'b0;
        cpu_resp_rdata  = '0;
        arr_req_valid   = 1'b0;
        arr_address     = '0;
        arr_data        = '0;
        arr_strobe      = '0;
        arr_wen_data    = '0;
        arr_wen_tag     = '0;
        arr_valid_dirty = '0;
        arr_tag         = '0;
        mem_req_valid   = 1'b0;
        mem_req_we      = 1'b0;
        mem_req_addr    = '0;
        mem_req_wdata   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    arr_req_valid = 1'b1;
                    arr_address   = cpu_req_addr;
                    state_next    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_resp_valid = 1'b1;
                    state_next     = IDLE;
                    if (req_we) begin
                        arr_req_valid                    = 1'b1;
                        arr_address                      = req_addr;
                        arr_data                         = req_wdata;
                        arr_strobe                       = req_strobe;
                        arr_wen_data[hit_way]            = 1'b1;
                        arr_wen_tag[hit_way]             = 1'b1;
                        arr_valid_dirty[2*hit_way +: 2]  = 2'b11;
                        arr_tag                          = req_tag;
                    end else begin
                        cpu_resp_rdata = arr_data_out[hit_way*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                    end
                end else begin
                    state_next = vic_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vic_tag, req_set, {OFF_W{1'b0}}};
                mem_req_wdata = vic_data;
                state_next    = mem_req_ready ? REFILL : WRITEBACK;
            end
            REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_addr[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                state_next    = mem_req_ready ? REFILL_WAIT : REFILL;
            end
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    arr_req_valid                = 1'b1;
                    arr_address                  = req_addr;
                    arr_data                     = merged;
                    arr_strobe                   = '1;
                    arr_wen_data[vic]            = 1'b1;
                    arr_wen_tag[vic]             = 1'b1;
                    arr_valid_dirty[2*vic +: 2]  = {req_we, 1'b1};
                    arr_tag                      = req_tag;
                    cpu_resp_valid               = 1'b1;
                    cpu_resp_rdata               = req_we ? '0 : mem_resp_rdata;
                    state_next                   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed bench for cache_controller with a behavioural 2-way, 4-set array model
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic [3:0]  cpu_req_strobe = '0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        arr_req_valid;
    logic [31:0] arr_address;
    logic [31:0] arr_data;
    logic [3:0]  arr_strobe;
    logic [1:0]  arr_wen_data;
    logic [1:0]  arr_wen_tag;
    logic [3:0]  arr_valid_dirty;
    logic [27:0] arr_tag;
    logic [63:0] arr_data_out = '0;
    logic [3:0]  arr_valid_dirty_out = '0;
    logic [55:0] arr_tag_out = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_data [2][4] = '{default: '0};
    logic [27:0] m_tag  [2][4] = '{default: '0};
    logic [1:0]  m_vd   [2][4] = '{default: '0};
    logic [1:0]  aset;

    cache_controller #(.ADDRESS_WIDTH(32), .SETS(4), .WAYS(2), .CACHE_LINE_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_strobe(cpu_req_strobe),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .arr_req_valid(arr_req_valid), .arr_address(arr_address), .arr_data(arr_data),
        .arr_strobe(arr_strobe), .arr_wen_data(arr_wen_data), .arr_wen_tag(arr_wen_tag),
        .arr_valid_dirty(arr_valid_dirty), .arr_tag(arr_tag), .arr_data_out(arr_data_out),
        .arr_valid_dirty_out(arr_valid_dirty_out), .arr_tag_out(arr_tag_out),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    assign aset = arr_address[3:2];

    // cache arrays: registered read of the addressed set, byte-strobed writes
    always @(posedge clk) begin
        if (arr_req_valid) begin
            for (int w = 0; w < 2; w++) begin
                arr_data_out[32*w +: 32]      <= m_data[w][aset];
                arr_tag_out[28*w +: 28]       <= m_tag[w][aset];
                arr_valid_dirty_out[2*w +: 2] <= m_vd[w][aset];
                if (arr_wen_data[w])
                    for (int b = 0; b < 4; b++)
                        if (arr_strobe[b]) m_data[w][aset][8*b +: 8] <= arr_data[8*b +: 8];
                if (arr_wen_tag[w]) begin
                    m_tag[w][aset] <= arr_tag;
                    m_vd[w][aset]  <= arr_valid_dirty[2*w +: 2];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        @(negedge clk);
        cpu_req_valid  = 1'b1;
        cpu_req_we     = we;
        cpu_req_addr   = addr;
        cpu_req_wdata  = wdata;
        cpu_req_strobe = strb;
        #1;
        chk("accept_ready", 64'(cpu_req_ready), 64'd1);
        chk("accept_arr_valid", 64'(arr_req_valid), 64'd1);
        chk("accept_arr_addr", 64'(arr_address), 64'(addr));
        chk("accept_wen", 64'({arr_wen_data, arr_wen_tag}), 64'd0);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_ready", 64'(cpu_req_ready), 64'd1);
        chk("rst_resp", 64'(cpu_resp_valid), 64'd0);
        chk("rst_arr", 64'(arr_req_valid), 64'd0);
        chk("rst_mem", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // load miss 0x10 into empty cache
        req(1'b0, 32'h10, '0, '0);
        chk("miss_lookup_resp", 64'(cpu_resp_valid), 64'd0);
        chk("miss_lookup_arr", 64'(arr_req_valid), 64'd0);
        chk("miss_lookup_mem", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("refill_valid", 64'(mem_req_valid), 64'd1);
        chk("refill_we", 64'(mem_req_we), 64'd0);
        chk("refill_addr", 64'(mem_req_addr), 64'h10);
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hAABBCCDD;
        #1;
        chk("fill_resp_valid", 64'(cpu_resp_valid), 64'd1);
        chk("fill_resp_data", 64'(cpu_resp_rdata), 64'hAABBCCDD);
        chk("fill_wen_data", 64'(arr_wen_data), 64'b01);
        chk("fill_wen_tag", 64'(arr_wen_tag), 64'b01);
        chk("fill_vd", 64'(arr_valid_dirty), 64'b0001);
        chk("fill_tag", 64'(arr_tag), 64'h1);
        chk("fill_strobe", 64'(arr_strobe), 64'hF);
        chk("fill_data", 64'(arr_data), 64'hAABBCCDD);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("back_idle", 64'(cpu_req_ready), 64'd1);

        // load hit 0x10
        req(1'b0, 32'h10, '0, '0);
        chk("hit_resp_valid", 64'(cpu_resp_valid), 64'd1);
        chk("hit_resp_data", 64'(cpu_resp_rdata), 64'hAABBCCDD);
        chk("hit_no_mem", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("hit_idle", 64'({cpu_req_ready, cpu_resp_valid}), 64'b10);

        // store hit 0x10, low two bytes
        req(1'b1, 32'h10, 32'h11223344, 4'b0011);
        chk("st_resp_valid", 64'(cpu_resp_valid), 64'd1);
        chk("st_resp_data", 64'(cpu_resp_rdata), 64'd0);
        chk("st_arr_valid", 64'(arr_req_valid), 64'd1);
        chk("st_wen", 64'({arr_wen_data, arr_wen_tag}), 64'b0101);
        chk("st_vd", 64'(arr_valid_dirty), 64'b0011);
        chk("st_data", 64'(arr_data), 64'h11223344);
        chk("st_strobe", 64'(arr_strobe), 64'b0011);
        chk("st_tag", 64'(arr_tag), 64'h1);
        req(1'b0, 32'h10, '0, '0);
        chk("st_reload", 64'(cpu_resp_rdata), 64'hAABB3344);

        // load 0x20 fills way1
        req(1'b0, 32'h20, '0, '0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("l20_addr", 64'(mem_req_addr), 64'h20);
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h20202020;
        #1;
        chk("l20_wen", 64'(arr_wen_data), 64'b10);
        chk("l20_vd", 64'(arr_valid_dirty), 64'b0100);
        chk("l20_tag", 64'(arr_tag), 64'h2);
        chk("l20_resp", 64'(cpu_resp_rdata), 64'h20202020);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // load 0x30 evicts dirty way0, ready held low 5 cycles
        req(1'b0, 32'h30, '0, '0);
        @(negedge clk);
        #1;
        chk("wb_valid", 64'(mem_req_valid), 64'd1);
        chk("wb_we", 64'(mem_req_we), 64'd1);
        chk("wb_addr", 64'(mem_req_addr), 64'h10);
        chk("wb_data", 64'(mem_req_wdata), 64'hAABB3344);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("wb_hold", 64'({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}),
                {30'd0, 2'b11, 32'h10, 32'hAABB3344} );
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("wb_last", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'({2'b11, 32'h10}));
        @(negedge clk);
        #1;
        chk("l30_refill", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'({2'b10, 32'h30}));
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h30303030;
        #1;
        chk("l30_wen", 64'(arr_wen_data), 64'b01);
        chk("l30_vd", 64'(arr_valid_dirty), 64'b0001);
        chk("l30_tag", 64'(arr_tag), 64'h3);
        chk("l30_resp", 64'(cpu_resp_rdata), 64'h30303030);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // store miss 0x44, top byte merged into refill
        req(1'b1, 32'h44, 32'hEE000000, 4'b1000);
        chk("sm_lookup_mem", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("sm_refill", 64'({mem_req_valid, mem_req_we, mem_req_addr}), 64'({2'b10, 32'h44}));
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h01020304;
        #1;
        chk("sm_data", 64'(arr_data), 64'hEE020304);
        chk("sm_vd", 64'(arr_valid_dirty), 64'b0011);
        chk("sm_wen", 64'(arr_wen_data), 64'b01);
        chk("sm_strobe", 64'(arr_strobe), 64'hF);
        chk("sm_tag", 64'(arr_tag), 64'h4);
        chk("sm_resp", 64'({cpu_resp_valid, cpu_resp_rdata}), 64'({1'b1, 32'h0}));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        req(1'b0, 32'h44, '0, '0);
        chk("sm_reload", 64'(cpu_resp_rdata), 64'hEE020304);

        // reset while waiting for refill data
        req(1'b0, 32'h80, '0, '0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("r80_refill", 64'(mem_req_addr), 64'h80);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("r80_wait", 64'({cpu_req_ready, cpu_resp_valid, mem_req_valid}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(cpu_req_ready), 64'd1);
        chk("mid_rst_outs", 64'({cpu_resp_valid, arr_req_valid, mem_req_valid}), 64'd0);
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h12345678;
        #1;
        chk("late_resp_ignored", 64'({cpu_resp_valid, arr_req_valid}), 64'd0);
        chk("late_resp_ready", 64'(cpu_req_ready), 64'd1);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // round-robin pointer back at way0 after reset
        req(1'b0, 32'h80, '0, '0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h80808080;
        #1;
        chk("rr_reset_wen", 64'(arr_wen_data), 64'b01);
        chk("rr_reset_tag", 64'(arr_tag), 64'h8);
        chk("rr_reset_resp", 64'(cpu_resp_rdata), 64'h80808080);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Initiator side of the cache memory request interface. Accepts single-word CPU loads/stores and drives array requests: address, data, strobe, per-way data/tag write enables, per-way valid/dirty, and tag.
- Consumes the 1-cycle-latency array read data (data, valid/dirty, tag per way) and performs tag compare.
- On a miss, writes back a dirty victim and refills the line from next-level memory.
- Sits between the CPU load/store port and the cache memory arrays.

Parameters:
- ADDRESS_WIDTH, 32, byte address width
- SETS, 1024, sets per way (power of two)
- WAYS, 2, associativity (power of two, ≥2)
- CACHE_LINE_SIZE, 32, line width in bits; equals the CPU data width
- TAG_WIDTH, ADDRESS_WIDTH-(clog2(SETS)+clog2(CACHE_LINE_SIZE/8)), tag bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  high only in IDLE
- cpu_req_we  in  1  1=store, 0=load
- cpu_req_addr  in  ADDRESS_WIDTH  byte address
- cpu_req_wdata  in  CACHE_LINE_SIZE  store data
- cpu_req_strobe  in  CACHE_LINE_SIZE/8  store byte enables
- cpu_resp_valid  out  1  one-cycle response pulse, no backpressure
- cpu_resp_rdata  out  CACHE_LINE_SIZE  load data; 0 for stores
- arr_req_valid  out  1  array request
- arr_address  out  ADDRESS_WIDTH  array address
- arr_data  out  CACHE_LINE_SIZE  array write data
- arr_strobe  out  CACHE_LINE_SIZE/8  array byte enables
- arr_wen_data  out  WAYS  per-way data write enable
- arr_wen_tag  out  WAYS  per-way tag and valid/dirty write enable
- arr_valid_dirty  out  2×WAYS  per-way {dirty,valid}; bit0=valid, bit1=dirty
- arr_tag  out  TAG_WIDTH  tag to write
- arr_data_out  in  CACHE_LINE_SIZE×WAYS  per-way read data
- arr_valid_dirty_out  in  2×WAYS  per-way read valid/dirty
- arr_tag_out  in  TAG_WIDTH×WAYS  per-way read tag
- mem_req_valid  out  1  next-level request
- mem_req_ready  in  1  request accepted when valid&ready
- mem_req_we  out  1  1=writeback
- mem_req_addr  out  ADDRESS_WIDTH  line-aligned address
- mem_req_wdata  out  CACHE_LINE_SIZE  writeback data
- mem_resp_valid  in  1  refill data valid
- mem_resp_rdata  in  CACHE_LINE_SIZE  refill data

Behaviour:
- Reset: async to IDLE. All outputs 0 except cpu_req_ready=1. Round-robin pointer=0, request latch cleared.
- Reset mid-operation: abandon the transaction immediately; no response issued; any later mem_resp_valid in IDLE is ignored.
- IDLE: on cpu_req_valid&cpu_req_ready, latch the request and pulse arr_req_valid=1 with all wen=0 and arr_address=cpu_req_addr, then go to LOOKUP.
- LOOKUP: hit[w] = valid[w] & (tag_out[w]==latched tag). At most one way hits; if several match, use the lowest index.
  - Load hit: cpu_resp_valid=1, rdata=data_out[hit], go to IDLE. Total latency 2 cycles from accept.
  - Store hit, same cycle: arr_req_valid=1, wen_data[hit]=wen_tag[hit]=1, valid_dirty[hit]=2'b11, arr_tag=latched tag, arr_data=wdata, arr_strobe=strobe. Pulse resp, go to IDLE.
  - Miss: victim = lowest-index invalid way; if all ways valid, victim = RR pointer and pointer increments mod WAYS. Capture victim data/tag/valid_dirty. If victim valid&dirty go to WRITEBACK, else REFILL.
- WRITEBACK: mem_req_valid=1, we=1, addr={victim tag, set, zero offset}, wdata=victim data. Hold all fields stable until ready, then go to REFILL.
- REFILL: mem_req_valid=1, we=0, addr=line-aligned latched address. Hold until ready, then go to REFILL_WAIT.
- REFILL_WAIT: wait for mem_resp_valid.
  - On valid, write the victim way: strobe all ones; data = rdata with store bytes merged per strobe for a store; valid_dirty={store,1}; tag=latched.
  - Same cycle pulse resp: rdata=mem_resp_rdata for a load, 0 for a store. Go to IDLE.
- mem_resp_valid outside REFILL_WAIT is ignored. Only one transaction is in flight at a time.
- arr_req_valid is high only in the cycles listed above. mem_req_valid never drops before ready.

Test Plan:
- SETS=4, WAYS=2. Load 0x10 into an empty cache → refill read 0x10; mem returns 0xAABBCCDD → resp 0xAABBCCDD; way0 set0 tag=1 written with valid_dirty=01.
- Load 0x10 again → resp 0xAABBCCDD exactly 2 cycles after accept, no mem request.
- Store 0x10, wdata 0x11223344, strobe 0011 → way0 written, strobe 0011, valid_dirty=11; the next load returns 0xAABB3344.
- Loads 0x20 then 0x30 (set0 full) → 0x30 evicts way0 (RR=0): writeback addr 0x10 data 0xAABB3344 precedes refill 0x30.
- Store miss 0x44, strobe 1000, wdata 0xEE000000, refill 0x01020304 → array data 0xEE020304, valid_dirty=11.
- mem_req_ready held low 5 cycles during WRITEBACK → fields stable; assert rst in REFILL_WAIT → outputs 0, ready=1, no resp.
